// File: rtl/reg_file_sched_pkg.sv
// Shared sizing and request types for the LC-3 register-file write scheduler.
package reg_file_sched_pkg;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 16;
  localparam int CNT_W    = 2;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef struct packed {
    logic      valid;
    reg_idx_t  dr;
    reg_data_t data;
  } wr_req_t;

endpackage

// File: rtl/reg_file_wr_sched_rr_arbiter2.sv
// Two-way round-robin arbiter with a global hold. On contention the requester
// that did not win last time is granted; last_grant resets to 1 so requester 0
// wins the first contention.
module rr_arbiter2
  import reg_file_sched_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       hold_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  logic last_grant_q, last_grant_d;

  // Grant selection: hold blocks everything, single requester wins outright.
  always_comb begin
    grant_o = 2'b00;
    if (!hold_i) begin
      if (&valid_i) grant_o = last_grant_q ? 2'b01 : 2'b10;
      else          grant_o = valid_i;
    end
  end

  // Remember the winner of any accepted request.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_o[1])      last_grant_d = 1'b1;
    else if (grant_o[0]) last_grant_d = 1'b0;
  end

  // Priority pointer register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/reg_file_wr_sched.sv
// Write scheduler for the LC-3 8x16 register file: arbitrates the execute and
// load writeback paths onto the single registered write port and keeps a
// per-register pending-write scoreboard for decode hazard detection.
// Optional: define RF_BYPASS_EN to expose same-cycle write data to decode.
module reg_file_wr_sched
  import reg_file_sched_pkg::*;
#(
  parameter int NUM_REGS = reg_file_sched_pkg::NUM_REGS,
  parameter int ADDR_W   = reg_file_sched_pkg::ADDR_W,
  parameter int DATA_W   = reg_file_sched_pkg::DATA_W,
  parameter int CNT_W    = reg_file_sched_pkg::CNT_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                hold,
  input  logic                req0_valid,
  input  logic [ADDR_W-1:0]   req0_dr,
  input  logic [DATA_W-1:0]   req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [ADDR_W-1:0]   req1_dr,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                req1_ready,
  output logic                rf_wr,
  output logic [ADDR_W-1:0]   rf_dr,
  output logic [DATA_W-1:0]   rf_din,
  input  logic                sb_set_valid,
  input  logic [ADDR_W-1:0]   sb_set_dr,
  output logic                sb_stall,
  input  logic [ADDR_W-1:0]   sr1,
  input  logic [ADDR_W-1:0]   sr2,
  output logic                sr1_busy,
  output logic                sr2_busy,
  output logic [NUM_REGS-1:0] busy,
  output logic                byp1_hit,
  output logic                byp2_hit,
  output logic [DATA_W-1:0]   byp1_data,
  output logic [DATA_W-1:0]   byp2_data
);

  logic [1:0]        grant;
  wr_req_t           req0_s, req1_s, sel_s;
  logic              rf_wr_q, rf_wr_d;
  logic [ADDR_W-1:0] rf_dr_q, rf_dr_d;
  logic [DATA_W-1:0] rf_din_q, rf_din_d;
  logic [NUM_REGS-1:0] busy_v, sat_v;

  rr_arbiter2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .hold_i  (hold),
    .valid_i ({req1_valid, req0_valid}),
    .grant_o (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign req0_s     = '{valid: req0_valid, dr: req0_dr, data: req0_data};
  assign req1_s     = '{valid: req1_valid, dr: req1_dr, data: req1_data};
  assign sel_s      = grant[1] ? req1_s : req0_s;

  // Next write-port contents: load the winner, otherwise keep dr/din.
  always_comb begin
    rf_wr_d  = (|grant) && sel_s.valid;
    rf_dr_d  = rf_dr_q;
    rf_din_d = rf_din_q;
    if (rf_wr_d) begin
      rf_dr_d  = sel_s.dr;
      rf_din_d = sel_s.data;
    end
  end

  // Registered write stage; reset drops any in-flight write immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_wr_q  <= 1'b0;
      rf_dr_q  <= '0;
      rf_din_q <= '0;
    end else begin
      rf_wr_q  <= rf_wr_d;
      rf_dr_q  <= rf_dr_d;
      rf_din_q <= rf_din_d;
    end
  end

  assign rf_wr  = rf_wr_q;
  assign rf_dr  = rf_dr_q;
  assign rf_din = rf_din_q;

  // A saturated counter refuses new sets; decode must retry.
  assign sb_stall = sat_v[sb_set_dr];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_sb
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inc, dec;

    assign inc = sb_set_valid && (sb_set_dr == ADDR_W'(i)) && !sb_stall;
    assign dec = rf_wr_q && (rf_dr_q == ADDR_W'(i));

    // Pending-write count: simultaneous set and retire cancel; no wrap at 0.
    always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec)                    cnt_d = cnt_q + 1'b1;
      else if (dec && !inc && cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end

    // Counter register.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign busy_v[i] = |cnt_q;
    assign sat_v[i]  = &cnt_q;
  end

  assign busy     = busy_v;
  assign sr1_busy = busy_v[sr1];
  assign sr2_busy = busy_v[sr2];

`ifdef RF_BYPASS_EN
  // reg_file reads return old data until the edge, so forward the write now.
  assign byp1_hit  = rf_wr_q && (rf_dr_q == sr1);
  assign byp2_hit  = rf_wr_q && (rf_dr_q == sr2);
  assign byp1_data = rf_din_q;
  assign byp2_data = rf_din_q;
`else
  assign byp1_hit  = 1'b0;
  assign byp2_hit  = 1'b0;
  assign byp1_data = '0;
  assign byp2_data = '0;
`endif

endmodule

// File: tb/tb_reg_file_wr_sched.sv
// Bench for reg_file_wr_sched: a cycle model checked every negedge plus
// directed scenarios with literal expectations.
module tb_reg_file_wr_sched;

  logic        clock = 1'b0;
  logic        reset, hold;
  logic        req0_valid, req1_valid, sb_set_valid;
  logic [2:0]  req0_dr, req1_dr, sb_set_dr, sr1, sr2;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, rf_wr, sb_stall, sr1_busy, sr2_busy;
  logic [2:0]  rf_dr;
  logic [15:0] rf_din, byp1_data, byp2_data;
  logic [7:0]  busy;
  logic        byp1_hit, byp2_hit;

  int n_tests = 0;
  int n_fail  = 0;

  reg_file_wr_sched dut (
    .clock(clock), .reset(reset), .hold(hold),
    .req0_valid(req0_valid), .req0_dr(req0_dr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dr(req1_dr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_wr(rf_wr), .rf_dr(rf_dr), .rf_din(rf_din),
    .sb_set_valid(sb_set_valid), .sb_set_dr(sb_set_dr), .sb_stall(sb_stall),
    .sr1(sr1), .sr2(sr2), .sr1_busy(sr1_busy), .sr2_busy(sr2_busy), .busy(busy),
    .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp1_data(byp1_data), .byp2_data(byp2_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_last;
  int   m_cnt[8];
  logic m_wr;
  int   m_dr;
  int   m_din;

  // Which requester is accepted under the current inputs (-1 = none).
  function automatic int winner();
    if (hold) return -1;
    if (req0_valid && req1_valid) return (m_last == 1) ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  initial begin
    m_last = 1; m_wr = 1'b0; m_dr = 0; m_din = 0;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_last = 1; m_wr = 1'b0; m_dr = 0; m_din = 0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      end else begin
        int g, set_r;
        g     = winner();
        set_r = (sb_set_valid && m_cnt[sb_set_dr] != 3) ? int'(sb_set_dr) : -1;
        if (set_r >= 0) m_cnt[set_r]++;
        if (m_wr && m_cnt[m_dr] > 0) m_cnt[m_dr]--;
        m_wr = (g >= 0);
        if (g == 0) begin m_dr = req0_dr; m_din = req0_data; m_last = 0; end
        if (g == 1) begin m_dr = req1_dr; m_din = req1_data; m_last = 1; end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clock);
      begin
        int g;
        logic [7:0] eb;
        g = winner();
        for (int i = 0; i < 8; i++) eb[i] = (m_cnt[i] != 0);
        chk("m_req0_ready", req0_ready, g == 0);
        chk("m_req1_ready", req1_ready, g == 1);
        chk("m_both_ready", req0_ready & req1_ready, 0);
        chk("m_rf_wr", rf_wr, m_wr);
        chk("m_rf_dr", rf_dr, m_dr);
        chk("m_rf_din", rf_din, m_din);
        chk("m_busy", busy, eb);
        chk("m_sb_stall", sb_stall, m_cnt[sb_set_dr] == 3);
        chk("m_sr1_busy", sr1_busy, m_cnt[sr1] != 0);
        chk("m_sr2_busy", sr2_busy, m_cnt[sr2] != 0);
`ifdef RF_BYPASS_EN
        chk("m_byp1_hit", byp1_hit, m_wr && m_dr == int'(sr1));
        chk("m_byp2_hit", byp2_hit, m_wr && m_dr == int'(sr2));
        chk("m_byp1_data", byp1_data, m_din);
        chk("m_byp2_data", byp2_data, m_din);
`else
        chk("m_byp_hits", {byp1_hit, byp2_hit}, 0);
        chk("m_byp_data", {byp1_data, byp2_data}, 0);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; hold = 1'b0;
    req0_valid = 1'b0; req0_dr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_dr = '0; req1_data = '0;
    sb_set_valid = 1'b0; sb_set_dr = '0; sr1 = '0; sr2 = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_rf_wr", rf_wr, 0);
    chk("rst_rf_dr", rf_dr, 0);
    chk("rst_rf_din", rf_din, 0);
    chk("rst_busy", busy, 0);

    // 1: single requester
    req0_valid = 1'b1; req0_dr = 3'd3; req0_data = 16'h1234;
    #1 chk("t1_ready", {req1_ready, req0_ready}, 2'b01);
    tick();
    req0_valid = 1'b0;
    chk("t1_rf_wr", rf_wr, 1);
    chk("t1_rf_dr", rf_dr, 3);
    chk("t1_rf_din", rf_din, 16'h1234);
    tick();
    chk("t1_rf_wr_low", rf_wr, 0);
    chk("t1_rf_dr_hold", rf_dr, 3);

    // req1 alone so the next contention starts with req0
    req1_valid = 1'b1; req1_dr = 3'd7; req1_data = 16'h0777;
    tick();
    req1_valid = 1'b0;
    chk("pre2_rf_dr", rf_dr, 7);

    // 2: contention alternates
    req0_valid = 1'b1; req0_dr = 3'd1; req0_data = 16'hA001;
    req1_valid = 1'b1; req1_dr = 3'd2; req1_data = 16'hB002;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t2_ready", {req1_ready, req0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("t2_rf_dr", rf_dr, (k % 2 == 0) ? 1 : 2);
    end

    // 3: hold blocks both
    hold = 1'b1;
    #1 chk("t3_hold_ready", {req1_ready, req0_ready}, 2'b00);
    tick();
    chk("t3_hold_rf_wr", rf_wr, 0);
    hold = 1'b0;
    #1 chk("t3_release_ready", {req1_ready, req0_ready}, 2'b01);
    tick();
    chk("t3_rf_dr", rf_dr, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // 4: scoreboard saturation and simultaneous set/retire
    sr1 = 3'd5; sr2 = 3'd0;
    sb_set_valid = 1'b1; sb_set_dr = 3'd5;
    tick(); tick(); tick();
    chk("t4_busy5", busy[5], 1);
    chk("t4_sr1_busy", sr1_busy, 1);
    chk("t4_stall", sb_stall, 1);
    tick();
    chk("t4_stall_again", sb_stall, 1);
    sb_set_valid = 1'b0;
    req0_valid = 1'b1; req0_dr = 3'd5; req0_data = 16'h0505;
    tick(); tick();
    req0_valid = 1'b0;
    sb_set_valid = 1'b1;
    #1 chk("t4_no_stall_at2", sb_stall, 0);
    tick();
    sb_set_valid = 1'b0;
    chk("t4_busy_after_same", busy[5], 1);
    req0_valid = 1'b1;
    tick(); tick();
    req0_valid = 1'b0;
    chk("t4_busy_at1", busy[5], 1);
    tick();
    chk("t4_busy_at0", busy[5], 0);

    // 5: async reset mid-write
    sb_set_valid = 1'b1; sb_set_dr = 3'd3;
    req0_valid = 1'b1; req0_dr = 3'd6; req0_data = 16'h6666;
    tick();
    sb_set_valid = 1'b0; req0_valid = 1'b0;
    chk("t5_rf_wr_before", rf_wr, 1);
    chk("t5_busy_before", busy, 8'h08);
    reset = 1'b1;
    #1;
    chk("t5_rf_wr_async", rf_wr, 0);
    chk("t5_busy_async", busy, 0);
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req0_dr = 3'd1;
    req1_valid = 1'b1; req1_dr = 3'd2;
    #1 chk("t5_first_grant", {req1_ready, req0_ready}, 2'b01);
    req1_valid = 1'b0;

    // 6: bypass
    req0_dr = 3'd4; req0_data = 16'hBEEF;
    tick();
    req0_valid = 1'b0;
    sr1 = 3'd4; sr2 = 3'd6;
    #1;
`ifdef RF_BYPASS_EN
    chk("t6_byp1_hit", byp1_hit, 1);
    chk("t6_byp1_data", byp1_data, 16'hBEEF);
    chk("t6_byp2_hit", byp2_hit, 0);
`else
    chk("t6_byp1_hit_off", byp1_hit, 0);
    chk("t6_byp2_hit_off", byp2_hit, 0);
`endif
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_wr_sched.md
Name: reg_file_wr_sched

Overview:
Schedules writes into the LC-3 8x16 register file, which has a single write port (wr/dr/din) and two async read ports (sr1/sr2).
- Arbitrates two write requesters: req0 = ALU/execute writeback, req1 = memory-load writeback.
- Drives the register-file write port from a registered stage.
- Keeps a per-register pending-write scoreboard so decode can detect RAW hazards on sr1/sr2.
- Sits between the writeback stages, decode, and reg_file.

Parameters:
NUM_REGS, 8, number of architectural registers
ADDR_W, 3, register index width; NUM_REGS = 2**ADDR_W
DATA_W, 16, register data width
CNT_W, 2, width of each pending-write counter (max 2**CNT_W-1 outstanding per register)

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state
hold  in  1  when high, no request is granted this cycle
req0_valid  in  1  requester 0 has a write
req0_dr  in  ADDR_W  requester 0 destination register
req0_data  in  DATA_W  requester 0 write data
req0_ready  out  1  requester 0 accepted this cycle (valid&&ready at posedge)
req1_valid / req1_dr / req1_data / req1_ready  same as req0 for requester 1
rf_wr  out  1  to reg_file wr (registered)
rf_dr  out  ADDR_W  to reg_file dr (registered)
rf_din  out  DATA_W  to reg_file din (registered)
sb_set_valid  in  1  decode issues an instruction writing sb_set_dr
sb_set_dr  in  ADDR_W  destination being marked pending
sb_stall  out  1  comb.: counter[sb_set_dr] saturated; set is refused
sr1, sr2  in  ADDR_W  decode source register indices
sr1_busy, sr2_busy  out  1  comb.: counter[srX] != 0
busy  out  NUM_REGS  comb.: bit i = counter[i] != 0
byp1_hit, byp2_hit  out  1  bypass hit (RF_BYPASS_EN only)
byp1_data, byp2_data  out  DATA_W  bypass data (RF_BYPASS_EN only)

Behaviour:
- Reset (async, active-high):
  - rf_wr=0, rf_dr=0, rf_din=0.
  - All counters 0.
  - last_grant=1, so req0 wins the first contention.
  - Reset asserted mid-operation discards the in-flight write; rf_wr falls immediately.
- Arbitration (combinational):
  - hold=1 -> both readies 0.
  - Otherwise exactly one valid requester -> its ready=1.
  - Both valid -> grant the requester not equal to last_grant (round-robin).
  - Never both readies high.
  - Ready may depend on valid; requesters hold valid/dr/data stable until accepted.
- Accept at posedge when reqX_valid && reqX_ready:
  - Load rf_wr=1, rf_dr=reqX_dr, rf_din=reqX_data.
  - last_grant=X.
  - No acceptance -> rf_wr=0; rf_dr and rf_din hold their values.
- Latency:
  - Acceptance edge N -> rf_wr high during cycle N..N+1.
  - reg_file ram updated at edge N+1.
  - Throughput: one write per cycle.
- Scoreboard, per register i, CNT_W-bit counter:
  - inc = sb_set_valid && sb_set_dr==i && !sb_stall.
  - dec = rf_wr && rf_dr==i (the write retiring at this edge).
  - inc&&dec -> unchanged; inc only -> +1; dec only -> -1.
  - dec at 0 cannot occur legally; counter holds at 0 (no wrap).
  - At max: sb_stall=1 and the set is ignored; decode must retry.
  - Cleared on reset.

Optional Feature:
RF_BYPASS_EN
- Defined:
  - byp1_hit = rf_wr && rf_dr==sr1; byp1_data = rf_din. Same for sr2.
  - Lets decode consume data in the cycle it is being written, since reg_file reads return old data until the edge.
- Undefined: byp*_hit=0 and byp*_data=0 constant; no comparator logic.

Decomposition:
- Package reg_file_sched_pkg holds:
  - NUM_REGS, ADDR_W, DATA_W, CNT_W defaults.
  - typedef reg_idx_t (logic [ADDR_W-1:0]).
  - typedef reg_data_t (logic [DATA_W-1:0]).
  - typedef wr_req_t struct {valid, dr, data}.
- One natural sub-module: rr_arbiter2 (2-way round-robin with hold, outputs grant vector and updates last_grant).
- Scoreboard counters stay inline in a generate loop.

Test Plan:
1. Reset, then req0_valid=1 dr=3 data=16'h1234 alone -> req0_ready=1; next cycle rf_wr=1 rf_dr=3 rf_din=16'h1234; following cycle rf_wr=0.
2. Both valid for 4 cycles (req0 dr=1, req1 dr=2) -> grants alternate 0,1,0,1; rf_dr sequence 1,2,1,2; never both readies high.
3. hold=1 with both valid -> both readies 0 and rf_wr=0 next cycle; release hold -> req0 granted when last_grant=1.
4. sb_set r5 three times -> busy[5]=1, counter=3, sb_stall=1 on a fourth set (ignored); set r5 and rf_wr r5 in the same cycle -> counter unchanged.
5. Assert reset asynchronously while rf_wr=1 -> rf_wr=0 before the next edge; busy=0; next contention grants req0 first.
6. With RF_BYPASS_EN: rf_wr=1 rf_dr=4 rf_din=16'hBEEF, sr1=4 -> byp1_hit=1 byp1_data=16'hBEEF; sr2=6 -> byp2_hit=0. Without the macro: hits stay 0.
